// File: rtl/mem_access_arbiter_pkg.sv
// Shared control definitions for the memory access arbiter: state encoding,
// owner/direction constants and the Moore output decode used by the top.
package mem_access_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ADDR   = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   localparam logic OWN_IF   = 1'b0;
   localparam logic OWN_EX   = 1'b1;
   localparam logic RW_READ  = 1'b1;
   localparam logic RW_WRITE = 1'b0;

   typedef struct packed {
      logic if_grant;
      logic ex_grant;
      logic mar_in_en;
      logic mdr_out_en;
      logic mdr_in_en;
      logic rw;
      logic enable;
      logic if_done;
      logic ex_done;
      logic timeout_err;
   } bus_ctrl_t;

   // Output strobes as a pure function of state, owner, direction and error flag.
   // wr is 1 for an execute write; fetch transactions always carry wr=0.
   function automatic bus_ctrl_t decode_ctrl(input state_t st, input logic owner,
                                             input logic wr, input logic err);
      bus_ctrl_t c;
      c = '0;
      case (st)
         ST_IDLE: begin
            c = '0;
         end
         ST_ADDR: begin
            c.if_grant   = (owner == OWN_IF);
            c.ex_grant   = (owner == OWN_EX);
            c.mar_in_en  = 1'b1;
            c.mdr_out_en = wr;
            c.rw         = wr ? RW_WRITE : RW_READ;
         end
         ST_ACCESS: begin
            c.if_grant   = (owner == OWN_IF);
            c.ex_grant   = (owner == OWN_EX);
            c.enable     = 1'b1;
            c.mdr_out_en = wr;
            c.rw         = wr ? RW_WRITE : RW_READ;
         end
         ST_DONE: begin
            c.if_grant    = (owner == OWN_IF);
            c.ex_grant    = (owner == OWN_EX);
            c.if_done     = (owner == OWN_IF);
            c.ex_done     = (owner == OWN_EX);
            c.mdr_in_en   = ~wr & ~err;
            c.timeout_err = err;
         end
         default: begin
            c = '0;
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/mem_access_arbiter_rr_arbiter2.sv
// Two-way round-robin pick between fetch and execute requests. When both
// request, the side that did not own the previous transaction wins.
module rr_arbiter2
   import mem_access_arbiter_pkg::*;
(
   input  logic if_req,
   input  logic ex_req,
   input  logic last_owner,
   output logic valid,
   output logic owner
);

   // Combinational pick; owner is only meaningful while valid is high.
   always_comb begin
      valid = if_req | ex_req;
      owner = OWN_IF;
      if (if_req && ex_req) begin
         owner = ~last_owner;
      end else if (ex_req) begin
         owner = OWN_EX;
      end else begin
         owner = OWN_IF;
      end
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// Memory port arbiter: grants fetch or execute one MAR/MDR/MFC transaction at
// a time, sequences the memory strobes and aborts on a missing MFC.
module mem_access_arbiter
   import mem_access_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 15,
   parameter int CNT_W          = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic if_req,
   input  logic ex_req,
   input  logic ex_wr,
   input  logic MFC,
   output logic if_grant,
   output logic ex_grant,
   output logic MAR_inEn,
   output logic MDR_outEn,
   output logic MDR_inEn,
   output logic RW,
   output logic Enable,
   output logic if_done,
   output logic ex_done,
   output logic timeout_err
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state_r, state_next_s;
   logic             owner_r, owner_next_s;
   logic             wr_r, wr_next_s;
   logic             err_r, err_next_s;
   logic             last_owner_r, last_owner_next_s;
   logic [CNT_W-1:0] cnt_r, cnt_next_s;
   logic             pick_valid_s, pick_owner_s;
   bus_ctrl_t        ctrl_r, ctrl_next_s;

   rr_arbiter2 u_rr (
      .if_req     (if_req),
      .ex_req     (ex_req),
      .last_owner (last_owner_r),
      .valid      (pick_valid_s),
      .owner      (pick_owner_s)
   );

   // Next-state logic for the transaction FSM, owner/direction latch and wait counter.
   always_comb begin
      state_next_s      = state_r;
      owner_next_s      = owner_r;
      wr_next_s         = wr_r;
      err_next_s        = err_r;
      last_owner_next_s = last_owner_r;
      cnt_next_s        = cnt_r;
      case (state_r)
         ST_IDLE: begin
            err_next_s = 1'b0;
            if (pick_valid_s) begin
               owner_next_s = pick_owner_s;
               wr_next_s    = (pick_owner_s == OWN_EX) ? ex_wr : 1'b0;
               state_next_s = ST_ADDR;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_ADDR: begin
            cnt_next_s   = '0;
            state_next_s = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (MFC) begin
               err_next_s   = 1'b0;
               state_next_s = ST_DONE;
            end else if (cnt_r == CNT_LAST) begin
               err_next_s   = 1'b1;
               state_next_s = ST_DONE;
            end else begin
               cnt_next_s   = cnt_r + CNT_ONE;
               state_next_s = ST_ACCESS;
            end
         end
         ST_DONE: begin
            last_owner_next_s = owner_r;
            state_next_s      = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
      // Outputs are registered from the decode of the next registered state,
      // so they always equal the Moore decode of the current state.
      ctrl_next_s = decode_ctrl(state_next_s, owner_next_s, wr_next_s, err_next_s);
   end

   // State, latched transaction attributes and registered output strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         owner_r      <= OWN_IF;
         wr_r         <= 1'b0;
         err_r        <= 1'b0;
         last_owner_r <= OWN_EX;
         cnt_r        <= '0;
         ctrl_r       <= '0;
      end else begin
         state_r      <= state_next_s;
         owner_r      <= owner_next_s;
         wr_r         <= wr_next_s;
         err_r        <= err_next_s;
         last_owner_r <= last_owner_next_s;
         cnt_r        <= cnt_next_s;
         ctrl_r       <= ctrl_next_s;
      end
   end

   assign if_grant    = ctrl_r.if_grant;
   assign ex_grant    = ctrl_r.ex_grant;
   assign MAR_inEn    = ctrl_r.mar_in_en;
   assign MDR_outEn   = ctrl_r.mdr_out_en;
   assign MDR_inEn    = ctrl_r.mdr_in_en;
   assign RW          = ctrl_r.rw;
   assign Enable      = ctrl_r.enable;
   assign if_done     = ctrl_r.if_done;
   assign ex_done     = ctrl_r.ex_done;
   assign timeout_err = ctrl_r.timeout_err;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Self-checking bench for mem_access_arbiter: directed table of transactions,
// randomized transactions against a transaction-level model, and an async
// reset sequence.
module tb_mem_access_arbiter;

   localparam int TO = 15;

   logic clk, reset, if_req, ex_req, ex_wr, MFC;
   logic if_grant, ex_grant, MAR_inEn, MDR_outEn, MDR_inEn, RW, Enable;
   logic if_done, ex_done, timeout_err;

   int checks = 0;
   int errors = 0;
   logic last_owner_m;

   mem_access_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .if_req(if_req), .ex_req(ex_req), .ex_wr(ex_wr),
      .MFC(MFC), .if_grant(if_grant), .ex_grant(ex_grant), .MAR_inEn(MAR_inEn),
      .MDR_outEn(MDR_outEn), .MDR_inEn(MDR_inEn), .RW(RW), .Enable(Enable),
      .if_done(if_done), .ex_done(ex_done), .timeout_err(timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic  ir;
      logic  er;
      logic  wr;
      int    d;        // MFC raised on ACCESS cycle d+1
      logic  own;      // expected owner (0=IF, 1=EX)
      logic  to;       // expected timeout
      string nm;
   } vec_t;

   // Order: if_grant ex_grant MAR_inEn MDR_outEn MDR_inEn RW Enable if_done ex_done timeout_err
   function automatic logic [9:0] outs();
      return {if_grant, ex_grant, MAR_inEn, MDR_outEn, MDR_inEn, RW, Enable,
              if_done, ex_done, timeout_err};
   endfunction

   // Expected strobes for a transaction phase: 0 idle, 1 address, 2 access, 3 done.
   function automatic logic [9:0] exp_vec(input int ph, input logic own,
                                          input logic wr, input logic err);
      logic gi, ge;
      gi = (own == 1'b0);
      ge = (own == 1'b1);
      if (ph == 1) return {gi, ge, 1'b1, wr, 1'b0, ~wr, 1'b0, 1'b0, 1'b0, 1'b0};
      if (ph == 2) return {gi, ge, 1'b0, wr, 1'b0, ~wr, 1'b1, 1'b0, 1'b0, 1'b0};
      if (ph == 3) return {gi, ge, 1'b0, 1'b0, ~wr & ~err, 1'b0, 1'b0, gi, ge, err};
      return 10'b0;
   endfunction

   task automatic check(input string nm, input string what, input logic [9:0] exp);
      logic [9:0] act;
      act = outs();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s/%s: got %b expected %b (gi ge mar mdro mdri rw en ifd exd to)",
                  nm, what, act, exp);
      end
   endtask

   // One complete transaction starting at a negedge with the DUT idle.
   task automatic run_txn(input logic ir, input logic er, input logic wr, input int d,
                          input logic own, input logic to, input string nm);
      logic wr_m;
      int   n;
      if_req = ir;
      ex_req = er;
      ex_wr  = wr;
      MFC    = 1'($urandom_range(0, 1));
      wr_m   = (own == 1'b1) ? wr : 1'b0;
      n      = (d + 1 > TO) ? TO : d + 1;
      @(posedge clk); @(negedge clk);
      check(nm, "addr", exp_vec(1, own, wr_m, 1'b0));
      ex_wr = 1'($urandom_range(0, 1));
      MFC   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) begin
         if (own == 1'b0) if_req = 1'b0; else ex_req = 1'b0;
      end
      for (int i = 1; i <= n; i++) begin
         @(posedge clk); @(negedge clk);
         check(nm, "access", exp_vec(2, own, wr_m, 1'b0));
         MFC = (i == d + 1);
      end
      @(posedge clk); @(negedge clk);
      check(nm, "done", exp_vec(3, own, wr_m, to));
      if (own == 1'b0) if_req = 1'b0; else ex_req = 1'b0;
      MFC = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      check(nm, "idle", 10'b0);
      last_owner_m = own;
   endtask

   vec_t tbl[11];

   initial begin
      logic ir, er, wr, own, to, pend_if, pend_ex;
      int   d;

      tbl[0]  = '{1'b1, 1'b0, 1'b0, 0,  1'b0, 1'b0, "fetch_alone"};
      tbl[1]  = '{1'b0, 1'b1, 1'b1, 3,  1'b1, 1'b0, "ex_write_delay"};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0, "both_1_if"};
      tbl[3]  = '{1'b1, 1'b1, 1'b0, 1,  1'b1, 1'b0, "both_2_ex"};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 0,  1'b0, 1'b0, "both_3_if"};
      tbl[5]  = '{1'b1, 1'b1, 1'b1, 2,  1'b1, 1'b0, "both_4_ex_wr"};
      tbl[6]  = '{1'b0, 1'b1, 1'b0, 20, 1'b1, 1'b1, "timeout_ex_rd"};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 0,  1'b0, 1'b0, "after_timeout"};
      tbl[8]  = '{1'b0, 1'b1, 1'b0, 14, 1'b1, 1'b0, "mfc_last_cycle"};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 15, 1'b0, 1'b1, "mfc_too_late"};
      tbl[10] = '{1'b1, 1'b1, 1'b1, 0,  1'b1, 1'b0, "both_after_if"};

      reset = 1'b1; if_req = 1'b0; ex_req = 1'b0; ex_wr = 1'b0; MFC = 1'b0;
      last_owner_m = 1'b1;
      repeat (2) @(negedge clk);
      check("reset", "outputs", 10'b0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 11; i++) begin
         run_txn(tbl[i].ir, tbl[i].er, tbl[i].wr, tbl[i].d, tbl[i].own, tbl[i].to, tbl[i].nm);
      end

      // Randomized transactions checked against the round-robin model.
      pend_if = 1'b0;
      pend_ex = 1'b0;
      for (int k = 0; k < 40; k++) begin
         ir = 1'($urandom_range(0, 1)) | pend_if;
         er = 1'($urandom_range(0, 1)) | pend_ex;
         if (!ir && !er) begin
            if ($urandom_range(0, 1) == 0) ir = 1'b1; else er = 1'b1;
         end
         wr  = 1'($urandom_range(0, 1));
         own = (ir && er) ? ~last_owner_m : (ir ? 1'b0 : 1'b1);
         if ($urandom_range(0, 3) == 0) d = $urandom_range(12, 17);
         else d = $urandom_range(0, 5);
         to = (d + 1 > TO);
         run_txn(ir, er, wr, d, own, to, "random");
         pend_if = ir && (own != 1'b0);
         pend_ex = er && (own != 1'b1);
      end
      if_req = 1'b0;
      ex_req = 1'b0;
      @(negedge clk);

      // Asynchronous reset in the middle of ACCESS.
      ex_req = 1'b1; ex_wr = 1'b0; MFC = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("reset_mid_access", "outputs", 10'b0);
      @(negedge clk);
      check("reset_held", "outputs", 10'b0);
      reset = 1'b0;
      last_owner_m = 1'b1;
      run_txn(1'b1, 1'b1, 1'b0, 0, 1'b0, 1'b0, "rst_fetch_first");
      run_txn(1'b0, 1'b1, 1'b0, 1, 1'b1, 1'b0, "rst_then_ex");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
